fc_mac_stream: RTL and testbench
================================

Name: fc_mac_stream

Overview:
- Time-multiplexed successor to the fully-combinational FC neuron layer.
- Accepts one input activation per beat on a valid/ready stream, together with that element's weights for NEURONS output channels.
- Each channel accumulates IN signed products, then applies optional ReLU and presents all channels as one output beat.
- Sits between an activation buffer/weight ROM reader and the next layer; trades the adder tree for IN cycles per vector.

Parameters:
- WIDTH, 8: signed activation width.
- WWIDTH, 8: signed weight width.
- IN, 128: elements per input vector (>=2).
- NEURONS, 4: parallel output channels.
- OW, WIDTH+WWIDTH+$clog2(IN): per-channel accumulator/output width (derived; do not override).

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- clr  input  1  synchronous abort: discard partial vector, return to ACC with count 0.
- relu_en  input  1  ReLU enable, sampled on the first beat of each vector.
- in_valid  input  1  x/w beat valid.
- in_ready  output  1  block can accept a beat.
- x  input  WIDTH  signed activation.
- w  input  NEURONS*WWIDTH  signed weights; channel n at bits [n*WWIDTH +: WWIDTH].
- out_valid  output  1  result beat valid.
- out_ready  input  1  downstream accepts result.
- z  output  NEURONS*OW  per-channel result; channel n at [n*OW +: OW].
- busy  output  1  high when count != 0 or out_valid.

Behaviour:
- Reset (async, rst=1): state=ACC, count=0, all accumulators=0, out_valid=0, z=0, relu latch=0, busy=0.
- States: ACC (collecting beats) and OUT (holding result).
- in_ready = (state==ACC) | (state==OUT & out_ready).
- Beat accepted when in_valid & in_ready:
  - First beat (count==0): acc[n] <= sext(x*w[n]) and relu latch <= relu_en.
  - Other beats: acc[n] <= acc[n] + sext(x*w[n]).
  - count increments each accepted beat.
- Arithmetic:
  - Full signed multiply, WIDTH+WWIDTH bits, sign-extended to OW.
  - Accumulation is exact; OW guarantees no overflow for IN terms.
  - No rounding, no saturation.
- Last beat (count==IN-1 accepted):
  - z[n] <= latched ReLU ? (final<0 ? 0 : final) : final, where final = acc[n]+product. The relu_en sampled on the first beat applies only if that first beat was this cycle (IN>=2 so never).
  - out_valid <= 1, count <= 0, state <= OUT.
  - Latency: result visible the cycle after the last beat is accepted.
- OUT state:
  - z and out_valid hold stable until out_valid & out_ready.
  - On handshake: out_valid <= 0, state <= ACC.
  - If a beat is accepted in the same cycle, it is the first beat of the next vector. The zero-bubble case requires out_ready=1 in that cycle.
- Back-pressure: with out_ready=0 in OUT, in_ready=0; no beat is lost or double-counted.
- clr (priority below rst, above everything else):
  - count <= 0, state <= ACC, out_valid <= 0.
  - Accumulators need not be cleared: the first-beat rule overwrites them.
  - A beat presented with clr=1 is not accepted; in_ready is forced 0 that cycle.
- z only changes on the last-beat update, reset, or never otherwise. clr does not modify z.
- busy is combinational from count and out_valid.

Test Plan:
- Basic:
  - Stimulus: IN=4, NEURONS=2, relu_en=0; x=1,2,3,4; w ch0=1 each, ch1=-2 each; out_ready=1.
  - Response: one cycle after the 4th beat, out_valid=1, z ch0=10, ch1=-20; total 5 cycles from first beat.
- ReLU:
  - Stimulus: same vector with relu_en=1 on the first beat, then relu_en toggled to 0 mid-vector.
  - Response: ch0=10, ch1=0.
- Extremes:
  - Stimulus: IN=128, x=-128, w=-128 for all beats (defaults).
  - Response: z ch=2,097,152 exact in OW=23 bits, no wrap. Same with w=127: -2,080,768.
- Back-pressure:
  - Stimulus: hold out_ready=0 for 5 cycles after out_valid, with in_valid=1 continuously.
  - Response: in_ready=0 and z stable during the hold. When out_ready rises, the first beat of the next vector is accepted that same cycle, and the next result is correct.
- Abort:
  - Stimulus: assert clr after 2 of 4 beats, then send a full vector x=1,1,1,1, w=3.
  - Response: z ch=12, out_valid exactly once; the aborted beats do not contribute.
- Async reset:
  - Stimulus: assert rst mid-vector between clock edges, and again in OUT.
  - Response: out_valid, busy and z go to 0 immediately without a clock edge; the next vector after release computes correctly.

Source files
------------

// File: rtl/fc_mac_stream.sv
`default_nettype none
// ============================================================================
// fc_mac_stream : streaming FC layer, one activation per beat into NEURONS MACs,
//                 optional ReLU, one result beat per IN-element vector.
// Revision      : 1.0
// ============================================================================
module fc_mac_stream #(
  parameter int WIDTH   = 8,
  parameter int WWIDTH  = 8,
  parameter int IN      = 128,
  parameter int NEURONS = 4,
  parameter int OW      = WIDTH + WWIDTH + $clog2(IN)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clr,
  input  logic                      relu_en,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WIDTH-1:0]          x,
  input  logic [NEURONS*WWIDTH-1:0] w,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [NEURONS*OW-1:0]     z,
  output logic                      busy
);

  localparam int              C_PW   = WIDTH + WWIDTH;
  localparam int              C_CW   = $clog2(IN);
  localparam logic [C_CW-1:0] C_LAST = C_CW'(IN - 1);

  typedef enum logic [0:0] {ST_ACC = 1'b0, ST_OUT = 1'b1} state_t;

  state_t                  state_q, state_d;
  logic [C_CW-1:0]         count_q, count_d;
  logic                    out_valid_q, out_valid_d;
  logic                    relu_q, relu_d;
  logic [NEURONS*OW-1:0]   acc_q, acc_d;
  logic [NEURONS*OW-1:0]   z_q, z_d;
  logic [NEURONS*OW-1:0]   sum_w, res_w;
  logic                    accept_w, first_w, last_w, relu_eff_w;

  assign in_ready   = ~clr & ((state_q == ST_ACC) | ((state_q == ST_OUT) & out_ready));
  assign accept_w   = in_valid & in_ready;
  assign first_w    = (count_q == '0);
  assign last_w     = (count_q == C_LAST);
  // The first beat's relu_en counts even before it lands in relu_q.
  assign relu_eff_w = first_w ? relu_en : relu_q;

  generate
    for (genvar n = 0; n < NEURONS; n++) begin : g_ch
      logic signed [C_PW-1:0] x_ext, w_ext, prod;
      logic signed [OW-1:0]   prod_ext, sum;

      assign x_ext    = C_PW'($signed(x));
      assign w_ext    = C_PW'($signed(w[n*WWIDTH +: WWIDTH]));
      assign prod     = x_ext * w_ext;
      assign prod_ext = OW'(prod);
      assign sum      = first_w ? prod_ext : ($signed(acc_q[n*OW +: OW]) + prod_ext);

      assign sum_w[n*OW +: OW] = sum;
      assign res_w[n*OW +: OW] = (relu_eff_w && sum[OW-1]) ? '0 : sum;
    end
  endgenerate

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    out_valid_d = out_valid_q;
    relu_d      = relu_q;
    acc_d       = acc_q;
    z_d         = z_q;
    if (clr) begin
      state_d     = ST_ACC;
      count_d     = '0;
      out_valid_d = 1'b0;
    end else begin
      if ((state_q == ST_OUT) && out_ready) begin
        out_valid_d = 1'b0;
        state_d     = ST_ACC;
      end
      if (accept_w) begin
        acc_d = sum_w;
        if (first_w) begin
          relu_d = relu_en;
        end
        if (last_w) begin
          z_d         = res_w;
          out_valid_d = 1'b1;
          state_d     = ST_OUT;
          count_d     = '0;
        end else begin
          count_d = count_q + C_CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_ACC;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      relu_q      <= 1'b0;
      acc_q       <= '0;
      z_q         <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      relu_q      <= relu_d;
      acc_q       <= acc_d;
      z_q         <= z_d;
    end
  end

  assign out_valid = out_valid_q;
  assign z         = z_q;
  assign busy      = (count_q != '0) | out_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_fc_mac_stream.sv
`default_nettype none
// ============================================================================
// tb_fc_mac_stream : self-checking bench, small (IN=4, NEURONS=2) and default
//                    instances. Revision 1.0
// ============================================================================
module tb_fc_mac_stream;

  localparam int SOW = 18;
  localparam int BOW = 23;
  localparam int NV  = 40;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic           s_clr = 0, s_relu = 0, s_iv = 0, s_ir, s_ov, s_or = 0, s_busy;
  logic [7:0]     s_x = '0;
  logic [15:0]    s_w = '0;
  logic [2*SOW-1:0] s_z;

  logic           b_clr = 0, b_relu = 0, b_iv = 0, b_ir, b_ov, b_or = 0, b_busy;
  logic [7:0]     b_x = '0;
  logic [31:0]    b_w = '0;
  logic [4*BOW-1:0] b_z;

  fc_mac_stream #(.IN(4), .NEURONS(2)) u_small (
    .clk(clk), .rst(rst), .clr(s_clr), .relu_en(s_relu), .in_valid(s_iv),
    .in_ready(s_ir), .x(s_x), .w(s_w), .out_valid(s_ov), .out_ready(s_or),
    .z(s_z), .busy(s_busy)
  );

  fc_mac_stream u_big (
    .clk(clk), .rst(rst), .clr(b_clr), .relu_en(b_relu), .in_valid(b_iv),
    .in_ready(b_ir), .x(b_x), .w(b_w), .out_valid(b_ov), .out_ready(b_or),
    .z(b_z), .busy(b_busy)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic longint sz(input int n);
    return longint'($signed(s_z[n*SOW +: SOW]));
  endfunction

  function automatic longint bz(input int n);
    return longint'($signed(b_z[n*BOW +: BOW]));
  endfunction

  task automatic s_set(input bit clr, input bit relu, input bit iv, input int xv,
                       input int w0, input int w1, input bit ordy);
    s_clr  = clr;
    s_relu = relu;
    s_iv   = iv;
    s_x    = 8'(xv);
    s_w    = {8'(w1), 8'(w0)};
    s_or   = ordy;
  endtask

  task automatic s_chk(input string tag, input bit e_ir, input bit e_ov, input bit e_busy,
                       input int e_z0, input int e_z1);
    chk({tag, ".in_ready"}, s_ir, e_ir);
    chk({tag, ".out_valid"}, s_ov, e_ov);
    chk({tag, ".busy"}, s_busy, e_busy);
    chk({tag, ".z0"}, sz(0), e_z0);
    chk({tag, ".z1"}, sz(1), e_z1);
  endtask

  typedef struct {
    bit clr, relu, iv, ordy;
    int x, w0, w1;
    bit e_ir, e_ov, e_busy;
    int e_z0, e_z1;
  } vec_t;

  function automatic vec_t mk(input bit clr, input bit relu, input bit iv, input int xv,
                              input int w0, input int w1, input bit ordy, input bit e_ir,
                              input bit e_ov, input bit e_busy, input int e_z0, input int e_z1);
    vec_t v;
    v.clr = clr; v.relu = relu; v.iv = iv; v.x = xv; v.w0 = w0; v.w1 = w1; v.ordy = ordy;
    v.e_ir = e_ir; v.e_ov = e_ov; v.e_busy = e_busy; v.e_z0 = e_z0; v.e_z1 = e_z1;
    return v;
  endfunction

  vec_t tbl[12];

  int rx[NV*4], rw0[NV*4], rw1[NV*4];
  bit rr[NV*4];
  longint q0[$], q1[$];

  initial begin
    int ov_cnt;
    int ptr, cyc;
    longint a0, a1, e0, e1;

    // Basic vector, then the ReLU vector with relu_en dropped mid-vector.
    tbl[0]  = mk(0, 0, 1, 1, 1, -2, 1,  1, 0, 0,  0,   0);
    tbl[1]  = mk(0, 0, 1, 2, 1, -2, 1,  1, 0, 1,  0,   0);
    tbl[2]  = mk(0, 0, 1, 3, 1, -2, 1,  1, 0, 1,  0,   0);
    tbl[3]  = mk(0, 0, 1, 4, 1, -2, 1,  1, 0, 1,  0,   0);
    tbl[4]  = mk(0, 0, 0, 0, 0,  0, 1,  1, 1, 1, 10, -20);
    tbl[5]  = mk(0, 0, 0, 0, 0,  0, 1,  1, 0, 0, 10, -20);
    tbl[6]  = mk(0, 1, 1, 1, 1, -2, 1,  1, 0, 0, 10, -20);
    tbl[7]  = mk(0, 0, 1, 2, 1, -2, 1,  1, 0, 1, 10, -20);
    tbl[8]  = mk(0, 0, 1, 3, 1, -2, 1,  1, 0, 1, 10, -20);
    tbl[9]  = mk(0, 0, 1, 4, 1, -2, 1,  1, 0, 1, 10, -20);
    tbl[10] = mk(0, 0, 0, 0, 0,  0, 1,  1, 1, 1, 10,   0);
    tbl[11] = mk(0, 0, 0, 0, 0,  0, 1,  1, 0, 0, 10,   0);

    // Reset state
    #2;
    s_chk("reset", 1, 0, 0, 0, 0);
    chk("reset.big_ov", b_ov, 0);
    chk("reset.big_z0", bz(0), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      s_set(tbl[i].clr, tbl[i].relu, tbl[i].iv, tbl[i].x, tbl[i].w0, tbl[i].w1, tbl[i].ordy);
      #1;
      s_chk($sformatf("tbl%0d", i), tbl[i].e_ir, tbl[i].e_ov, tbl[i].e_busy, tbl[i].e_z0, tbl[i].e_z1);
    end

    // Back-pressure with in_valid held high throughout
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      s_set(0, 0, 1, 2, 3, -1, 0);
      #1 chk("bp.fill_ir", s_ir, 1);
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      s_set(0, 0, 1, 5, 1, 1, 0);
      #1 s_chk($sformatf("bp.hold%0d", k), 0, 1, 1, 24, -8);
    end
    @(negedge clk);
    s_set(0, 0, 1, 5, 1, 1, 1);
    #1 s_chk("bp.release", 1, 1, 1, 24, -8);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      s_set(0, 0, 1, 5, 1, 1, 1);
      #1 chk("bp.next_ir", s_ir, 1);
      chk("bp.next_ov", s_ov, 0);
    end
    @(negedge clk);
    s_set(0, 0, 0, 0, 0, 0, 1);
    #1 s_chk("bp.result", 1, 1, 1, 20, 20);
    @(negedge clk);
    #1 chk("bp.drain_ov", s_ov, 0);

    // Abort after two beats
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      s_set(0, 0, 1, 7, 3, 3, 1);
    end
    @(negedge clk);
    s_set(1, 0, 1, 7, 3, 3, 1);
    #1 chk("abort.clr_ir", s_ir, 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      s_set(0, 0, 1, 1, 3, 3, 1);
      #1 if (k == 0) chk("abort.busy_after_clr", s_busy, 0);
    end
    ov_cnt = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      s_set(0, 0, 0, 0, 0, 0, 1);
      #1;
      if (k == 0) begin
        chk("abort.z0", sz(0), 12);
        chk("abort.z1", sz(1), 12);
      end
      if (s_ov) ov_cnt++;
    end
    chk("abort.ov_once", ov_cnt, 1);

    // Async reset mid-vector
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      s_set(0, 0, 1, 5, 1, 1, 1);
    end
    @(negedge clk);
    s_set(0, 0, 0, 0, 0, 0, 1);
    #1 chk("arst.pre_busy", s_busy, 1);
    #1 rst = 1'b1;
    #1 s_chk("arst.mid", 1, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      s_set(0, 0, 1, 1, 2, 2, 0);
    end
    @(negedge clk);
    s_set(0, 0, 0, 0, 0, 0, 0);
    #1 s_chk("arst.out_pre", 0, 1, 1, 8, 8);
    #1 rst = 1'b1;
    #1 s_chk("arst.out", 1, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      s_set(0, 0, 1, k + 1, 1, -1, 1);
    end
    @(negedge clk);
    s_set(0, 0, 0, 0, 0, 0, 1);
    #1 s_chk("arst.after", 1, 1, 1, 10, -10);
    @(negedge clk);

    // Randomized vectors against a plain-arithmetic reference
    for (int v = 0; v < NV; v++) begin
      e0 = 0;
      e1 = 0;
      for (int k = 0; k < 4; k++) begin
        rx[v*4+k]  = int'($urandom_range(0, 255)) - 128;
        rw0[v*4+k] = int'($urandom_range(0, 255)) - 128;
        rw1[v*4+k] = int'($urandom_range(0, 255)) - 128;
        rr[v*4+k]  = 1'($urandom_range(0, 1));
        e0 += longint'(rx[v*4+k]) * rw0[v*4+k];
        e1 += longint'(rx[v*4+k]) * rw1[v*4+k];
      end
      if (rr[v*4] && e0 < 0) e0 = 0;
      if (rr[v*4] && e1 < 0) e1 = 0;
      q0.push_back(e0);
      q1.push_back(e1);
    end
    ptr = 0;
    cyc = 0;
    while (q0.size() > 0 && cyc < 5000) begin
      @(negedge clk);
      cyc++;
      if (ptr < NV*4)
        s_set(0, rr[ptr], ($urandom_range(0, 9) < 7), rx[ptr], rw0[ptr], rw1[ptr],
              ($urandom_range(0, 9) < 7));
      else
        s_set(0, 0, 0, 0, 0, 0, ($urandom_range(0, 9) < 7));
      #1;
      if (s_ov && s_or) begin
        a0 = q0.pop_front();
        a1 = q1.pop_front();
        chk("rand.z0", sz(0), a0);
        chk("rand.z1", sz(1), a1);
      end
      if (s_iv && s_ir) ptr++;
    end
    chk("rand.all_results", q0.size(), 0);
    @(negedge clk);
    s_set(0, 0, 0, 0, 0, 0, 1);
    #1 chk("rand.idle_ov", s_ov, 0);

    // Extremes on the default-size instance
    for (int pass = 0; pass < 2; pass++) begin
      for (int k = 0; k < 128; k++) begin
        @(negedge clk);
        b_iv = 1'b1;
        b_or = 1'b1;
        b_x  = 8'h80;
        b_w  = (pass == 0) ? {4{8'h80}} : {4{8'h7f}};
      end
      @(negedge clk);
      b_iv = 1'b0;
      #1 chk("ext.ov", b_ov, 1);
      for (int n = 0; n < 4; n++)
        chk($sformatf("ext%0d.z%0d", pass, n), bz(n), (pass == 0) ? 2097152 : -2080768);
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
